// File: rtl/sec_display_driver.sv
// Seconds display driver: BCD split, two-digit 7-segment scan,
// ring pulse stretcher with display blink while the buzzer sounds.
module sec_display_driver #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 2,
    parameter int RING_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec,
    input  logic       ring,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       buzzer
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HW = $clog2(RING_HOLD + 1);

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(RING_HOLD);

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    logic [5:0]    r_sec_q;
    logic          r_ring_q;
    logic          r_ring_d;
    logic [SW-1:0] r_scan_cnt;
    logic          r_dig_sel;
    logic [HW-1:0] r_hold_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;
    logic          r_buzzer;

    logic [5:0] w_tens_bin;
    logic [5:0] w_ones_bin;
    logic [6:0] w_ones_seg;
    logic [6:0] w_tens_seg;
    logic       w_scan_wrap;
    logic       w_trig;
    logic       w_hold_nz;

    function automatic logic [6:0] seg7(input logic [5:0] d);
        logic [6:0] s;
        case (d)
            6'd0:    s = 7'h3F;
            6'd1:    s = 7'h06;
            6'd2:    s = 7'h5B;
            6'd3:    s = 7'h4F;
            6'd4:    s = 7'h66;
            6'd5:    s = 7'h6D;
            6'd6:    s = 7'h7D;
            6'd7:    s = 7'h07;
            6'd8:    s = 7'h7F;
            6'd9:    s = 7'h6F;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign w_tens_bin  = r_sec_q / 6'd10;
    assign w_ones_bin  = r_sec_q % 6'd10;
    assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
    assign w_trig      = r_ring_q & ~r_ring_d;
    assign w_hold_nz   = (r_hold_cnt != '0);

    // Out-of-range seconds show dashes; a zero tens digit is blanked.
    always_comb begin
        w_ones_seg = SEG_DASH;
        w_tens_seg = SEG_DASH;
        if (r_sec_q <= 6'd59) begin
            w_ones_seg = seg7(w_ones_bin);
            w_tens_seg = (r_sec_q < 6'd10) ? SEG_BLANK : seg7(w_tens_bin);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec_q  <= '0;
            r_ring_q <= 1'b0;
            r_ring_d <= 1'b0;
        end else begin
            r_sec_q  <= sec;
            r_ring_q <= ring;
            r_ring_d <= r_ring_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_dig_sel  <= 1'b0;
        end else begin
            if (w_scan_wrap) begin
                r_scan_cnt <= '0;
                r_dig_sel  <= ~r_dig_sel;
            end else begin
                r_scan_cnt <= r_scan_cnt + SW'(1);
            end
        end
    end

    // A new ring edge always reloads, so back-to-back rings merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= '0;
            r_buzzer   <= 1'b0;
        end else begin
            if (w_trig) begin
                r_hold_cnt <= HOLD_LOAD;
            end else if (w_hold_nz) begin
                r_hold_cnt <= r_hold_cnt - HW'(1);
            end
            r_buzzer <= w_hold_nz;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            if (w_trig) begin
                r_blink_cnt <= '0;
                r_blink_on  <= 1'b1;
            end else if (w_hold_nz) begin
                if (w_scan_wrap) begin
                    if (r_blink_cnt == BLINK_LAST) begin
                        r_blink_cnt <= '0;
                        r_blink_on  <= ~r_blink_on;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BW'(1);
                    end
                end
            end else begin
                r_blink_cnt <= '0;
                r_blink_on  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= '0;
            r_an  <= 2'b00;
        end else begin
            r_seg <= r_dig_sel ? w_tens_seg : w_ones_seg;
            if (!r_blink_on) begin
                r_an <= 2'b00;
            end else begin
                r_an <= r_dig_sel ? 2'b10 : 2'b01;
            end
        end
    end

    assign seg    = r_seg;
    assign an     = r_an;
    assign buzzer = r_buzzer;

endmodule

// File: tb/tb_sec_display_driver.sv
// Bench for sec_display_driver: per-cycle model check plus
// directed digit, ring-stretch, blink and async-reset vectors.
module tb_sec_display_driver;

    localparam int SD = 4;
    localparam int BD = 2;
    localparam int RH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] sec;
    logic       ring;
    logic [6:0] seg;
    logic [1:0] an;
    logic       buzzer;

    int nchk = 0;
    int nerr = 0;
    int k = 0;

    logic [5:0] sec_in  [0:4095];
    logic       ring_in [0:4095];
    logic [6:0] tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    sec_display_driver #(
        .SCAN_DIV (SD),
        .BLINK_DIV(BD),
        .RING_HOLD(RH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sec   (sec),
        .ring  (ring),
        .seg   (seg),
        .an    (an),
        .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // k = rising edges since reset release; inputs seen at edge k.
    always @(posedge clk) begin
        if (reset) begin
            k = 0;
        end else begin
            k = k + 1;
            sec_in[k]  = sec;
            ring_in[k] = ring;
        end
    end

    function automatic bit r_at(int i);
        return (i <= 0) ? 1'b0 : ring_in[i];
    endfunction

    function automatic bit trig_at(int j);
        return (j >= 1) && r_at(j - 1) && !r_at(j - 2);
    endfunction

    function automatic int last_trig(int n);
        for (int j = n; j >= 1; j--)
            if (trig_at(j)) return j;
        return -1;
    endfunction

    function automatic int hold_at(int n);
        int j;
        j = last_trig(n);
        if (j < 0) return 0;
        return (RH - (n - j) > 0) ? RH - (n - j) : 0;
    endfunction

    function automatic bit blink_at(int n);
        int j;
        int w;
        j = last_trig(n);
        if (j < 0 || n > j + RH) return 1'b1;
        w = 0;
        for (int m = j + 1; m <= n; m++)
            if (m % SD == 0) w++;
        return ((w / BD) % 2) == 0;
    endfunction

    function automatic logic [6:0] ones_code(int s);
        if (s >= 60) return 7'h40;
        return tbl[s % 10];
    endfunction

    function automatic logic [6:0] tens_code(int s);
        if (s >= 60) return 7'h40;
        if (s < 10) return 7'h00;
        return tbl[s / 10];
    endfunction

    always @(negedge clk) begin
        if (!reset && k >= 1) begin
            int ds;
            int s;
            logic [6:0] es;
            logic [1:0] ea;
            ds = ((k - 1) / SD) % 2;
            s  = int'(sec_in[k - 1]);
            es = (ds == 1) ? tens_code(s) : ones_code(s);
            ea = !blink_at(k - 1) ? 2'b00 : ((ds == 1) ? 2'b10 : 2'b01);
            chk("model_seg", seg, es);
            chk("model_an", an, ea);
            chk("model_buzzer", buzzer, (hold_at(k - 1) != 0));
        end
    end

    task automatic digits(input logic [5:0] s, input logic [6:0] eo,
                          input logic [6:0] et);
        bit so;
        bit st;
        so = 0;
        st = 0;
        sec = s;
        repeat (3) @(negedge clk);
        repeat (8) begin
            @(negedge clk);
            if (an == 2'b01) begin
                chk($sformatf("ones_sec%0d", s), seg, eo);
                so = 1;
            end else if (an == 2'b10) begin
                chk($sformatf("tens_sec%0d", s), seg, et);
                st = 1;
            end
        end
        chk($sformatf("both_digits_sec%0d", s), so && st, 1);
    endtask

    task automatic ring_run(input int mode, input int exp_len);
        int first;
        int last;
        int high;
        int rises;
        int zall;
        int zlate;
        bit prev;
        bit zf [0:79];
        first = -1;
        last = -1;
        high = 0;
        rises = 0;
        zall = 0;
        zlate = 0;
        prev = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (buzzer) begin
                high++;
                if (first < 0) first = n;
                last = n;
            end
            if (buzzer && !prev) rises++;
            prev = buzzer;
            zf[n] = (an == 2'b00);
            if (zf[n]) zall++;
            case (mode)
                0:       ring = (n == 0);
                1:       ring = (n == 0) || (n == 10);
                default: ring = (n < 40);
            endcase
        end
        ring = 0;
        for (int n = 0; n < 80; n++)
            if (last >= 0 && n >= last + 2 && zf[n]) zlate++;
        chk($sformatf("ring%0d_rise_delay", mode), first, 3);
        chk($sformatf("ring%0d_high_len", mode), high, exp_len);
        chk($sformatf("ring%0d_single_run", mode), rises, 1);
        chk($sformatf("ring%0d_blink_seen", mode), zall > 0, 1);
        chk($sformatf("ring%0d_no_gap_after", mode), zlate, 0);
    endtask

    initial begin
        int guard;
        bit found;
        reset = 1;
        sec = 0;
        ring = 0;
        sec_in[0] = 0;
        ring_in[0] = 0;
        repeat (3) @(negedge clk);
        chk("reset_seg", seg, 7'h00);
        chk("reset_an", an, 2'b00);
        chk("reset_buzzer", buzzer, 0);
        reset = 0;

        @(negedge clk);
        chk("first_an", an, 2'b01);
        chk("first_seg", seg, 7'h3F);
        repeat (4) @(negedge clk);
        chk("zero_tens_an", an, 2'b10);
        chk("zero_tens_seg", seg, 7'h00);

        digits(6'd47, 7'h07, 7'h66);
        guard = 0;
        while ((k % 8) != 0 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        chk("align_bound", guard < 16, 1);
        sec = 6'd48;
        @(negedge clk);
        chk("lat_ones_old", seg, 7'h07);
        @(negedge clk);
        chk("lat_ones_new", seg, 7'h7F);

        digits(6'd59, 7'h6F, 7'h6D);
        digits(6'd9,  7'h6F, 7'h00);
        digits(6'd10, 7'h3F, 7'h06);
        digits(6'd60, 7'h40, 7'h40);
        digits(6'd63, 7'h40, 7'h40);

        sec = 6'd30;
        repeat (4) @(negedge clk);
        ring_run(0, 16);
        ring_run(1, 26);
        ring_run(2, 16);

        sec = 6'd35;
        repeat (4) @(negedge clk);
        ring = 1;
        @(negedge clk);
        ring = 0;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (buzzer && an == 2'b10) found = 1;
        end
        chk("buzz_tens_found", found, 1);
        chk("pre_reset_seg", seg, 7'h4F);
        #2 reset = 1;
        #1;
        chk("async_seg", seg, 7'h00);
        chk("async_an", an, 2'b00);
        chk("async_buzzer", buzzer, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("post_reset_an", an, 2'b01);
        chk("post_reset_buzzer", buzzer, 0);
        repeat (6) @(negedge clk);
        chk("post_reset_quiet", buzzer, 0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
